qcw_pulse_sequencer: RTL



---
 rtl/qcw_pkg.sv | 28 ++
 rtl/qcw_ramp_gen.sv | 39 +++
 rtl/qcw_pulse_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/qcw_pkg.sv
// Shared definitions for the QCW pulse sequencer: FSM state encoding,
// fault-counter sizing and the saturating fault increment.
package qcw_pkg;

   localparam int FAULT_W = 4;

   typedef logic [FAULT_W-1:0] fault_cnt_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RUN      = 3'd1;
   localparam logic [2:0] ST_DONE     = 3'd2;
   localparam logic [2:0] ST_COOLDOWN = 3'd3;
   localparam logic [2:0] ST_LOCKOUT  = 3'd4;

   localparam fault_cnt_t FAULT_SAT = '1;

   // The fault count pins at its maximum rather than wrapping back to zero.
   function automatic fault_cnt_t faultInc(input fault_cnt_t count);
      fault_cnt_t result;
      if (count == FAULT_SAT) begin
         result = count;
      end else begin
         result = count + fault_cnt_t'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/qcw_ramp_gen.sv
// Saturating drive-level accumulator: load sets the level and latches the step,
// step adds the latched increment (clamped to all-ones), clear zeroes the level.
module qcw_ramp_gen #(
   parameter int RAMP_W = 10
) (
   input  logic              system_clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic [RAMP_W-1:0] i_loadLevel,
   input  logic [RAMP_W-1:0] i_loadStep,
   input  logic              i_step,
   input  logic              i_clear,
   output logic [RAMP_W-1:0] o_level
);

   logic [RAMP_W-1:0] r_level;
   logic [RAMP_W-1:0] r_step;
   logic [RAMP_W:0]   w_sum;

   // One extra bit catches the carry so an overflowing step clamps instead of wrapping.
   assign w_sum = {1'b0, r_level} + {1'b0, r_step};

   always_ff @(posedge system_clk) begin
      if (reset) begin
         r_level <= '0;
         r_step  <= '0;
      end else if (i_clear) begin
         r_level <= '0;
      end else if (i_load) begin
         r_level <= i_loadLevel;
         r_step  <= i_loadStep;
      end else if (i_step) begin
         r_level <= w_sum[RAMP_W] ? '1 : w_sum[RAMP_W-1:0];
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/qcw_pulse_sequencer.sv
// QCW burst sequencer: accept, ramped drive, done framing, cooldown and fault lockout.
// Define QCW_ABORT_EN to add the abort_req input that ends a burst early without a fault.
module qcw_pulse_sequencer
   import qcw_pkg::*;
#(
   parameter int PULSE_W         = 16,
   parameter int RAMP_W          = 10,
   parameter int COOLDOWN_CYCLES = 100000,
   parameter int MAX_FAULTS      = 3
) (
   input  logic               system_clk,
   input  logic               reset,
   input  logic               fire_req,
   input  logic [PULSE_W-1:0] pulse_len,
   input  logic [RAMP_W-1:0]  ramp_start,
   input  logic [RAMP_W-1:0]  ramp_step,
   input  logic               qcw_halt,
   input  logic               fault_clear,
`ifdef QCW_ABORT_EN
   input  logic               abort_req,
`endif
   output logic               fire_ack,
   output logic               qcw_start,
   output logic               qcw_done,
   output logic               drive_en,
   output logic [RAMP_W-1:0]  drive_level,
   output logic               busy,
   output logic               locked_out,
   output logic [FAULT_W-1:0] fault_count
);

   localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

   logic [2:0]         r_state;
   logic [PULSE_W-1:0] r_remain;
   logic [COOL_W-1:0]  r_cool;
   logic               r_lockPending;
   logic               r_fireAck;
   logic               r_start;
   logic               r_done;
   logic               r_driveEn;
   logic               r_busy;
   logic               r_locked;
   fault_cnt_t         r_faults;

   logic [2:0]         w_nextState;
   logic               w_accept;
   logic               w_rampLoad;
   logic               w_rampStep;
   logic               w_rampClear;
   logic               w_abortReq;
   logic               w_lastCycle;
   logic               w_haltEnd;
   logic               w_normalEnd;
   logic               w_burstEnd;
   fault_cnt_t         w_faultInc;
   logic               w_lockNow;

`ifdef QCW_ABORT_EN
   assign w_abortReq = abort_req;
`else
   assign w_abortReq = 1'b0;
`endif

   // A halt wins over a normal or aborted end on the same cycle, so it is always counted.
   assign w_lastCycle = (r_remain == PULSE_W'(1));
   assign w_haltEnd   = (r_state == ST_RUN) && qcw_halt;
   assign w_normalEnd = (r_state == ST_RUN) && !qcw_halt && w_lastCycle;
   assign w_burstEnd  = (r_state == ST_RUN) && (qcw_halt || w_abortReq || w_lastCycle);
   assign w_faultInc  = faultInc(r_faults);
   assign w_lockNow   = (w_faultInc >= FAULT_W'(MAX_FAULTS));

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_rampLoad  = 1'b0;
      w_rampStep  = 1'b0;
      w_rampClear = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fire_req && (pulse_len != '0)) begin
               w_accept    = 1'b1;
               w_rampLoad  = 1'b1;
               w_nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_burstEnd) begin
               w_rampClear = 1'b1;
               w_nextState = ST_DONE;
            end else begin
               w_rampStep = 1'b1;
            end
         end
         ST_DONE: begin
            w_nextState = r_lockPending ? ST_LOCKOUT : ST_COOLDOWN;
         end
         ST_COOLDOWN: begin
            if (r_cool == '0) begin
               w_nextState = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (fault_clear) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Every status output is registered straight from the next-state decision.
   always_ff @(posedge system_clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_remain      <= '0;
         r_cool        <= '0;
         r_lockPending <= 1'b0;
         r_fireAck     <= 1'b0;
         r_start       <= 1'b0;
         r_done        <= 1'b0;
         r_driveEn     <= 1'b0;
         r_busy        <= 1'b0;
         r_locked      <= 1'b0;
         r_faults      <= '0;
      end else begin
         r_state   <= w_nextState;
         r_fireAck <= w_accept;
         r_start   <= w_accept;
         r_done    <= w_burstEnd;
         r_driveEn <= (w_nextState == ST_RUN);
         r_busy    <= (w_nextState != ST_IDLE);
         r_locked  <= (w_nextState == ST_LOCKOUT);

         if (w_accept) begin
            r_remain <= pulse_len;
         end else if (r_state == ST_RUN) begin
            r_remain <= r_remain - PULSE_W'(1);
         end

         if (r_state == ST_DONE) begin
            r_cool <= COOL_W'(COOLDOWN_CYCLES - 1);
         end else if ((r_state == ST_COOLDOWN) && (r_cool != '0)) begin
            r_cool <= r_cool - COOL_W'(1);
         end

         // An aborted burst leaves the fault history untouched.
         if (w_haltEnd) begin
            r_faults      <= w_faultInc;
            r_lockPending <= w_lockNow;
         end else if (w_normalEnd) begin
            r_faults      <= '0;
            r_lockPending <= 1'b0;
         end else if (w_burstEnd) begin
            r_lockPending <= 1'b0;
         end else if (fault_clear) begin
            r_faults <= '0;
         end
      end
   end

   qcw_ramp_gen #(
      .RAMP_W (RAMP_W)
   ) u_rampGen (
      .system_clk  (system_clk),
      .reset       (reset),
      .i_load      (w_rampLoad),
      .i_loadLevel (ramp_start),
      .i_loadStep  (ramp_step),
      .i_step      (w_rampStep),
      .i_clear     (w_rampClear),
      .o_level     (drive_level)
   );

   assign fire_ack    = r_fireAck;
   assign qcw_start   = r_start;
   assign qcw_done    = r_done;
   assign drive_en    = r_driveEn;
   assign busy        = r_busy;
   assign locked_out  = r_locked;
   assign fault_count = r_faults;

endmodule
